// File: rtl/org_unit_mt.sv
// -----------------------------------------------------------------------------
// org_unit_mt
//
// Multi-thread organisation stage. Sits between the data-return interface and
// the execution stage:
//   - Read returns are buffered per thread in a tagged slot table (one slot per
//     thread id), so returns may arrive out of order and ahead of their thread.
//   - An issued thread register block is merged with its thread's buffered
//     return data into one registered execution packet (ev_*).
//   - The output register honours downstream back-pressure (ev_ready). An issue
//     whose slot holds no data stalls (issue_ready=0).
//   - A return that lands on an occupied slot (and is not replacing data being
//     consumed in the same cycle) is dropped and raises a sticky error flag.
//
// Configuration macro:
//   ORG_UNIT_BYPASS_EN - when defined, a return arriving in the same cycle as
//                        an issue to the same, empty slot is forwarded straight
//                        into the packet instead of being stored first.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ret_valid       read-return valid
//   ret_id          destination thread id of the return
//   ret_data        returned data
//   issue_valid     thread issue request
//   issue_id        id of the thread being issued
//   issue_thread    thread register block
//   issue_ready     issue accepted this cycle when issue_valid is high
//   ev_valid        execution packet valid
//   ev_id           packet thread id
//   ev_data         packet data
//   ev_thread       packet thread block
//   ev_ready        downstream accepts the packet
//   err_overwrite   sticky: a return hit an already-full slot and was dropped
//   stall_cnt       saturating count of cycles with issue_valid & !issue_ready
// -----------------------------------------------------------------------------
module org_unit_mt #(
  parameter int ID_W     = 4,
  parameter int DATA_W   = 512,
  parameter int THREAD_W = 512,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ret_valid,
  input  logic [ID_W-1:0]     ret_id,
  input  logic [DATA_W-1:0]   ret_data,
  input  logic                issue_valid,
  input  logic [ID_W-1:0]     issue_id,
  input  logic [THREAD_W-1:0] issue_thread,
  output logic                issue_ready,
  output logic                ev_valid,
  output logic [ID_W-1:0]     ev_id,
  output logic [DATA_W-1:0]   ev_data,
  output logic [THREAD_W-1:0] ev_thread,
  input  logic                ev_ready,
  output logic                err_overwrite,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int NUM_THREADS = 2 ** ID_W;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } out_state_e;

  // Slot table
  logic [NUM_THREADS-1:0] slot_full_q;
  logic [NUM_THREADS-1:0] slot_full_d;
  logic [NUM_THREADS-1:0] slot_wr_s;
  logic [DATA_W-1:0]      slot_data_q [NUM_THREADS];

  // Output register
  out_state_e             out_state_q;
  logic [ID_W-1:0]        ev_id_q;
  logic [DATA_W-1:0]      ev_data_q;
  logic [THREAD_W-1:0]    ev_thread_q;

  // Status
  logic                   err_overwrite_q;
  logic                   err_set_s;
  logic [CNT_W-1:0]       stall_cnt_q;

  // Handshake terms
  logic                   out_free_s;
  logic                   bypass_hit_s;
  logic                   avail_s;
  logic                   accept_s;
  logic [DATA_W-1:0]      accept_data_s;

  // The output register can take a new packet when empty or draining this cycle.
  assign out_free_s = (out_state_q == ST_IDLE) || ev_ready;

`ifdef ORG_UNIT_BYPASS_EN
  // Same-cycle return to the issuing thread's empty slot can be forwarded.
  assign bypass_hit_s = ret_valid && (ret_id == issue_id) && !slot_full_q[issue_id];
`else
  assign bypass_hit_s = 1'b0;
`endif

  assign avail_s       = slot_full_q[issue_id] || bypass_hit_s;
  assign issue_ready   = out_free_s && avail_s;
  assign accept_s      = issue_valid && issue_ready;
  assign accept_data_s = bypass_hit_s ? ret_data : slot_data_q[issue_id];

  // Slot occupancy next-state, data write enables and overwrite detection.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_wr_s   = '0;
    err_set_s   = 1'b0;

    // Consumption first, so a same-cycle refill below overrides it.
    if (accept_s) begin
      slot_full_d[issue_id] = 1'b0;
    end else begin
      slot_full_d = slot_full_q;
    end

    if (ret_valid) begin
      if (!slot_full_q[ret_id]) begin
        if (bypass_hit_s && accept_s) begin
          // Forwarded into the packet; the slot stays empty.
          slot_wr_s[ret_id] = 1'b0;
        end else begin
          slot_wr_s[ret_id]   = 1'b1;
          slot_full_d[ret_id] = 1'b1;
        end
      end else if (accept_s && (issue_id == ret_id)) begin
        // Old data leaves with the issue, new data replaces it.
        slot_wr_s[ret_id]   = 1'b1;
        slot_full_d[ret_id] = 1'b1;
      end else begin
        err_set_s = 1'b1;
      end
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Slot occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full_q <= '0;
    end else begin
      slot_full_q <= slot_full_d;
    end
  end

  // Slot data storage; contents are only read while the slot is FULL, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (slot_wr_s[i]) begin
        slot_data_q[i] <= ret_data;
      end else begin
        slot_data_q[i] <= slot_data_q[i];
      end
    end
  end

  // Output packet FSM: payload is forced to zero whenever no packet is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state_q <= ST_IDLE;
      ev_id_q     <= '0;
      ev_data_q   <= '0;
      ev_thread_q <= '0;
    end else begin
      case (out_state_q)
        ST_IDLE: begin
          if (accept_s) begin
            out_state_q <= ST_VALID;
            ev_id_q     <= issue_id;
            ev_data_q   <= accept_data_s;
            ev_thread_q <= issue_thread;
          end else begin
            out_state_q <= ST_IDLE;
            ev_id_q     <= '0;
            ev_data_q   <= '0;
            ev_thread_q <= '0;
          end
        end
        ST_VALID: begin
          if (accept_s) begin
            out_state_q <= ST_VALID;
            ev_id_q     <= issue_id;
            ev_data_q   <= accept_data_s;
            ev_thread_q <= issue_thread;
          end else if (ev_ready) begin
            out_state_q <= ST_IDLE;
            ev_id_q     <= '0;
            ev_data_q   <= '0;
            ev_thread_q <= '0;
          end else begin
            out_state_q <= ST_VALID;
            ev_id_q     <= ev_id_q;
            ev_data_q   <= ev_data_q;
            ev_thread_q <= ev_thread_q;
          end
        end
        default: begin
          out_state_q <= ST_IDLE;
          ev_id_q     <= '0;
          ev_data_q   <= '0;
          ev_thread_q <= '0;
        end
      endcase
    end
  end

  // Sticky overwrite error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overwrite_q <= 1'b0;
    end else if (err_set_s) begin
      err_overwrite_q <= 1'b1;
    end else begin
      err_overwrite_q <= err_overwrite_q;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (issue_valid && !issue_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign ev_valid      = (out_state_q == ST_VALID);
  assign ev_id         = ev_id_q;
  assign ev_data       = ev_data_q;
  assign ev_thread     = ev_thread_q;
  assign err_overwrite = err_overwrite_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_org_unit_mt.sv
// -----------------------------------------------------------------------------
// tb_org_unit_mt
//
// Self-checking bench for org_unit_mt with default parameters. A behavioural
// model (per-thread occupancy/data arrays plus the expected packet) predicts
// issue_ready every cycle and all outputs after every clock edge. Directed
// sequences cover the documented scenarios, then randomized traffic on a small
// id range exercises collisions, back-pressure and overwrites.
// -----------------------------------------------------------------------------
module tb_org_unit_mt;

  localparam int IW = 4;
  localparam int DW = 512;
  localparam int TW = 512;
  localparam int CW = 16;
  localparam int NT = 16;

  logic          clk;
  logic          rst;
  logic          ret_valid;
  logic [IW-1:0] ret_id;
  logic [DW-1:0] ret_data;
  logic          issue_valid;
  logic [IW-1:0] issue_id;
  logic [TW-1:0] issue_thread;
  logic          issue_ready;
  logic          ev_valid;
  logic [IW-1:0] ev_id;
  logic [DW-1:0] ev_data;
  logic [TW-1:0] ev_thread;
  logic          ev_ready;
  logic          err_overwrite;
  logic [CW-1:0] stall_cnt;

  org_unit_mt dut (
    .clk          (clk),
    .rst          (rst),
    .ret_valid    (ret_valid),
    .ret_id       (ret_id),
    .ret_data     (ret_data),
    .issue_valid  (issue_valid),
    .issue_id     (issue_id),
    .issue_thread (issue_thread),
    .issue_ready  (issue_ready),
    .ev_valid     (ev_valid),
    .ev_id        (ev_id),
    .ev_data      (ev_data),
    .ev_thread    (ev_thread),
    .ev_ready     (ev_ready),
    .err_overwrite(err_overwrite),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit            m_full [NT];
  logic [DW-1:0] m_data [NT];
  bit            m_ev_valid;
  logic [IW-1:0] m_ev_id;
  logic [DW-1:0] m_ev_data;
  logic [TW-1:0] m_ev_thread;
  bit            m_err;
  int            m_stall;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
    end
    m_ev_valid = 1'b0;
    m_ev_id = '0;
    m_ev_data = '0;
    m_ev_thread = '0;
    m_err = 1'b0;
    m_stall = 0;
  endtask

  task automatic check_outputs();
    check_eq("ev_valid", DW'(ev_valid), DW'(m_ev_valid));
    check_eq("ev_id", DW'(ev_id), DW'(m_ev_id));
    check_eq("ev_data", ev_data, m_ev_data);
    check_eq("ev_thread", ev_thread, m_ev_thread);
    check_eq("err_overwrite", DW'(err_overwrite), DW'(m_err));
    check_eq("stall_cnt", DW'(stall_cnt), DW'(m_stall));
  endtask

  // One clock cycle: drive inputs, check issue_ready, advance model, check outputs.
  task automatic step(input bit rv, input logic [IW-1:0] rid, input logic [DW-1:0] rd,
                      input bit iv, input logic [IW-1:0] iid, input logic [TW-1:0] ith,
                      input bit er, output bit acc);
    bit byp;
    bit exp_rdy;
    bit old_full;
    ret_valid = rv; ret_id = rid; ret_data = rd;
    issue_valid = iv; issue_id = iid; issue_thread = ith;
    ev_ready = er;
    #1;
    byp = 1'b0;
`ifdef ORG_UNIT_BYPASS_EN
    byp = rv && (rid == iid) && !m_full[iid];
`endif
    exp_rdy = (!m_ev_valid || er) && (m_full[iid] || byp);
    check_eq("issue_ready", DW'(issue_ready), DW'(exp_rdy));
    acc = iv && exp_rdy;

    if (iv && !exp_rdy && m_stall < 65535) m_stall++;

    // Packet register
    if (acc) begin
      m_ev_valid = 1'b1;
      m_ev_id = iid;
      m_ev_thread = ith;
      m_ev_data = byp ? rd : m_data[iid];
    end else if (er) begin
      m_ev_valid = 1'b0;
      m_ev_id = '0;
      m_ev_thread = '0;
      m_ev_data = '0;
    end

    // Slot table
    old_full = m_full[rid];
    if (acc) m_full[iid] = 1'b0;
    if (rv) begin
      if (!old_full) begin
        if (!(acc && byp)) begin
          m_full[rid] = 1'b1;
          m_data[rid] = rd;
        end
      end else if (acc && iid == rid) begin
        m_full[rid] = 1'b1;
        m_data[rid] = rd;
      end else begin
        m_err = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit er);
    bit a;
    step(1'b0, '0, '0, 1'b0, '0, '0, er, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ret_valid = 1'b1; ret_id = 4'd7; ret_data = rnd_wide();
    issue_valid = 1'b1; issue_id = 4'd9; issue_thread = rnd_wide();
    ev_ready = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    ret_valid = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] d2;
    logic [TW-1:0] th;
    bit a;
    int s0;
    int guard;
    bit pend_v;
    logic [IW-1:0] pend_id;
    logic [TW-1:0] pend_th;

    rst = 1'b0;
    ret_valid = 1'b0; ret_id = '0; ret_data = '0;
    issue_valid = 1'b0; issue_id = '0; issue_thread = '0;
    ev_ready = 1'b1;
    model_reset();

    // Reset with both request inputs active
    do_reset();
    idle(1'b1);

    // Return to thread 10, then issue it
    d = '0; d[10*32 +: 32] = 32'd6;
    th = '0; th[10*32 +: 32] = 32'd35;
    step(1'b1, 4'd10, d, 1'b0, '0, '0, 1'b1, a);
    step(1'b0, '0, '0, 1'b1, 4'd10, th, 1'b1, a);
    check_eq("t2_ev_id", DW'(ev_id), DW'(10));
    check_eq("t2_u32", DW'(ev_data[10*32 +: 32]), DW'(6));
    check_eq("t2_thr", DW'(ev_thread[10*32 +: 32]), DW'(35));
    idle(1'b1);
    check_eq("t2_drain", DW'(ev_valid), DW'(0));

    // Stall on miss for thread 15
    s0 = stall_cnt;
    th = rnd_wide();
    d = DW'(32'hAB);
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1, 4'd15, th, 1'b1, a);
    step(1'b1, 4'd15, d, 1'b1, 4'd15, th, 1'b1, a);
    guard = 0;
    while (!a && guard < 4) begin
      step(1'b0, '0, '0, 1'b1, 4'd15, th, 1'b1, a);
      guard++;
    end
    check_eq("t3_acc", DW'(a), DW'(1));
`ifdef ORG_UNIT_BYPASS_EN
    check_eq("t3_stall", DW'(stall_cnt - s0), DW'(3));
`else
    check_eq("t3_stall", DW'(stall_cnt - s0), DW'(4));
`endif
    check_eq("t3_id", DW'(ev_id), DW'(15));
    check_eq("t3_data", ev_data, DW'(32'hAB));
    idle(1'b1);

    // Overwrite of a full slot is dropped
    d = rnd_wide(); d2 = rnd_wide();
    step(1'b1, 4'd3, d, 1'b0, '0, '0, 1'b1, a);
    step(1'b1, 4'd3, d2, 1'b0, '0, '0, 1'b1, a);
    check_eq("t4_err", DW'(err_overwrite), DW'(1));
    step(1'b0, '0, '0, 1'b1, 4'd3, rnd_wide(), 1'b1, a);
    check_eq("t4_data", ev_data, d);
    idle(1'b1);

    // Back-pressure hold, then consecutive packets
    step(1'b1, 4'd1, rnd_wide(), 1'b0, '0, '0, 1'b1, a);
    step(1'b1, 4'd2, rnd_wide(), 1'b0, '0, '0, 1'b1, a);
    th = rnd_wide();
    step(1'b0, '0, '0, 1'b1, 4'd1, rnd_wide(), 1'b0, a);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, '0, '0, 1'b1, 4'd2, th, 1'b0, a);
      check_eq("t5_hold_id", DW'(ev_id), DW'(1));
      check_eq("t5_hold_rdy", DW'(a), DW'(0));
    end
    step(1'b0, '0, '0, 1'b1, 4'd2, th, 1'b1, a);
    check_eq("t5_second", DW'(ev_id), DW'(2));
    idle(1'b1);

    // Same-cycle consume and refill of slot 5
    d = rnd_wide(); d2 = rnd_wide();
    step(1'b1, 4'd5, d, 1'b0, '0, '0, 1'b1, a);
    step(1'b1, 4'd5, d2, 1'b1, 4'd5, rnd_wide(), 1'b1, a);
    check_eq("t6_old", ev_data, d);
    step(1'b0, '0, '0, 1'b1, 4'd5, rnd_wide(), 1'b1, a);
    check_eq("t6_new", ev_data, d2);
    idle(1'b1);

    // Reset mid-operation with buffered data and a held packet
    step(1'b1, 4'd6, rnd_wide(), 1'b0, '0, '0, 1'b1, a);
    step(1'b1, 4'd8, rnd_wide(), 1'b1, 4'd6, rnd_wide(), 1'b0, a);
    do_reset();
    idle(1'b1);
    step(1'b0, '0, '0, 1'b1, 4'd8, rnd_wide(), 1'b1, a);  // slot 8 must be empty again

    // Randomized traffic on ids 0..3; a stalled issue is held stable
    model_reset();
    do_reset();
    pend_v = 1'b0; pend_id = '0; pend_th = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pend_v && ($urandom_range(0, 99) < 60)) begin
        pend_v = 1'b1;
        pend_id = IW'($urandom_range(0, 3));
        pend_th = rnd_wide();
      end
      step(($urandom_range(0, 99) < 45), IW'($urandom_range(0, 3)), rnd_wide(),
           pend_v, pend_id, pend_th, ($urandom_range(0, 99) < 70), a);
      if (a) pend_v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
